// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Function : pops 1-2 operands, drives one ALU op, pushes the result.
//            Define DIVZERO_TRAP_EN to trap idiv/irem by zero before issue.
// Revision : 1.0
// ============================================================================
module alu_sequencer #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid_i,
    output logic             op_ready_o,
    input  logic [3:0]       op_aluop_i,
    input  logic             stack_empty_i,
    output logic             stack_pop_o,
    input  logic [WIDTH-1:0] stack_rdata_i,
    output logic             stack_push_o,
    output logic [WIDTH-1:0] stack_wdata_o,
    output logic [3:0]       alu_op_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic             alu_start_o,
    input  logic             alu_done_i,
    input  logic [WIDTH-1:0] alu_result_i,
    output logic             busy_o,
    output logic [2:0]       err_code_o,
    input  logic             err_clear_i
);

    localparam int          c_CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [15:0] c_LEGAL_OPS = 16'hB33F;
    localparam logic [3:0]  c_OP_IDIV   = 4'h3;
    localparam logic [3:0]  c_OP_IREM   = 4'h4;
    localparam logic [3:0]  c_OP_INEG   = 4'h5;
    localparam logic [2:0]  c_ERR_NONE  = 3'd0;
    localparam logic [2:0]  c_ERR_UFLOW = 3'd1;
    localparam logic [2:0]  c_ERR_ILLEG = 3'd2;
    localparam logic [2:0]  c_ERR_TMOUT = 3'd3;
    localparam logic [2:0]  c_ERR_DIV0  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POP1  = 3'd1,
        S_POP2  = 3'd2,
        S_LATCH = 3'd3,
        S_EXEC  = 3'd4,
        S_WAIT  = 3'd5,
        S_PUSH  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    state_t             state_q,  state_d;
    logic [3:0]         aluop_q,  aluop_d;
    logic [WIDTH-1:0]   a_q,      a_d;
    logic [WIDTH-1:0]   b_q,      b_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [c_CNT_W-1:0] cnt_q,    cnt_d;
    logic [2:0]         err_q,    err_d;

    logic w_unary;
    logic w_divzero;
    logic w_accept;

    assign w_unary  = (aluop_q == c_OP_INEG);
    assign w_accept = op_valid_i && op_ready_o;

`ifdef DIVZERO_TRAP_EN
    assign w_divzero = ((aluop_q == c_OP_IDIV) || (aluop_q == c_OP_IREM)) && (b_q == '0);
`else
    assign w_divzero = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            aluop_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            err_q    <= c_ERR_NONE;
        end else begin
            state_q  <= state_d;
            aluop_q  <= aluop_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        aluop_d      = aluop_q;
        a_d          = a_q;
        b_d          = b_q;
        result_d     = result_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        stack_pop_o  = 1'b0;
        stack_push_o = 1'b0;
        alu_start_o  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    aluop_d = op_aluop_i;
                    if (c_LEGAL_OPS[op_aluop_i]) begin
                        state_d = S_POP1;
                    end else begin
                        err_d   = c_ERR_ILLEG;
                        state_d = S_ERR;
                    end
                end
            end
            S_POP1: begin
                if (stack_empty_i) begin
                    err_d   = c_ERR_UFLOW;
                    state_d = S_ERR;
                end else begin
                    stack_pop_o = 1'b1;
                    state_d     = w_unary ? S_LATCH : S_POP2;
                end
            end
            S_POP2: begin
                // Top of stack arrives here and becomes operand B.
                b_d = stack_rdata_i;
                if (stack_empty_i) begin
                    err_d   = c_ERR_UFLOW;
                    state_d = S_ERR;
                end else begin
                    stack_pop_o = 1'b1;
                    state_d     = S_LATCH;
                end
            end
            S_LATCH: begin
                a_d = stack_rdata_i;
                if (w_unary) begin
                    b_d = '0;
                end
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (w_divzero) begin
                    err_d   = c_ERR_DIV0;
                    state_d = S_ERR;
                end else begin
                    alu_start_o = 1'b1;
                    if (alu_done_i) begin
                        result_d = alu_result_i;
                        state_d  = S_PUSH;
                    end else begin
                        cnt_d   = c_CNT_W'(1);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // A done on the last permitted cycle still wins over the timeout.
                if (alu_done_i) begin
                    result_d = alu_result_i;
                    state_d  = S_PUSH;
                end else if (cnt_q == c_CNT_W'(TIMEOUT)) begin
                    err_d   = c_ERR_TMOUT;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            S_PUSH: begin
                stack_push_o = 1'b1;
                state_d      = S_IDLE;
            end
            S_ERR: begin
                if (err_clear_i) begin
                    err_d   = c_ERR_NONE;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // op_ready is qualified by rst_n so that every output reads 0 while held in reset.
    assign op_ready_o    = (state_q == S_IDLE) && rst_n;
    assign busy_o        = (state_q != S_IDLE);
    assign stack_wdata_o = stack_push_o ? result_q : '0;
    assign alu_op_o      = aluop_q;
    assign alu_a_o       = a_q;
    assign alu_b_o       = b_q;
    assign err_code_o    = err_q;

    a_no_pop_push: assert property (@(posedge clk) disable iff (!rst_n)
        !(stack_pop_o && stack_push_o));
    a_ready_idle: assert property (@(posedge clk) disable iff (!rst_n)
        !(op_ready_o && busy_o));

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Function : self-checking bench for alu_sequencer with stack/ALU responders.
// Revision : 1.0
// ============================================================================
module tb_alu_sequencer;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 64;
`ifdef DIVZERO_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid, op_ready, stack_empty, stack_pop, stack_push;
    logic [3:0]  op_aluop, alu_op;
    logic [31:0] stack_rdata, stack_wdata, alu_a, alu_b, alu_result;
    logic        alu_start, alu_done, busy, err_clear;
    logic [2:0]  err_code;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    logic [31:0] stk[$];
    bit          pend_pop, pend_push, alu_pend;
    logic [31:0] pend_wdata, alu_res;
    int          alu_cnt, alu_dly;

    int          pop_n, push_n, both_n, start_n, push_cyc, start_cyc, acc_cyc, end_cyc;
    logic [31:0] push_val, st_a, st_b;
    logic [2:0]  end_err;
    int          legal_ops[11] = '{0, 1, 2, 3, 4, 5, 8, 9, 12, 13, 15};

    always #5 clk = ~clk;

    alu_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid_i(op_valid), .op_ready_o(op_ready), .op_aluop_i(op_aluop),
        .stack_empty_i(stack_empty), .stack_pop_o(stack_pop), .stack_rdata_i(stack_rdata),
        .stack_push_o(stack_push), .stack_wdata_o(stack_wdata),
        .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_start_o(alu_start),
        .alu_done_i(alu_done), .alu_result_i(alu_result),
        .busy_o(busy), .err_code_o(err_code), .err_clear_i(err_clear)
    );

    // Behaviour of the external ALU: any deterministic function of (op, A, B) will do.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a * b;
            4'h3: return (b == 0) ? 32'hDEAD0000 : a / b;
            4'h4: return (b == 0) ? a : a % b;
            4'h5: return 32'd0 - a;
            4'h8: return a & b;
            4'h9: return a | b;
            4'hC: return a << b[4:0];
            4'hD: return a >> b[4:0];
            4'hF: return a ^ b;
            default: return 32'hBAD0BAD0;
        endcase
    endfunction

    // One clock: apply last cycle's stack actions just after the edge, observe at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        alu_done = 1'b0;
        if (pend_pop) begin
            stack_rdata = (stk.size() > 0) ? stk.pop_back() : 32'hDEADBEEF;
            pend_pop = 1'b0;
        end
        if (pend_push) begin
            stk.push_back(pend_wdata);
            pend_push = 1'b0;
        end
        stack_empty = (stk.size() == 0);
        @(negedge clk);
        if (stack_pop) begin
            pop_n++;
            pend_pop = 1'b1;
        end
        if (stack_push) begin
            push_n++;
            push_cyc   = cyc;
            push_val   = stack_wdata;
            pend_push  = 1'b1;
            pend_wdata = stack_wdata;
        end
        if (stack_pop && stack_push) both_n++;
        if (alu_start) begin
            start_n++;
            start_cyc = cyc;
            st_a      = alu_a;
            st_b      = alu_b;
            alu_res   = ref_alu(alu_op, alu_a, alu_b);
            alu_pend  = 1'b1;
            alu_cnt   = 0;
        end
        if (alu_pend) begin
            if (alu_cnt == alu_dly) begin
                alu_done   = 1'b1;
                alu_result = alu_res;
                alu_pend   = 1'b0;
            end else begin
                alu_cnt++;
            end
        end
    endtask

    task automatic clear_obs();
        pop_n = 0; push_n = 0; both_n = 0; start_n = 0;
        push_cyc = -1; start_cyc = -1; push_val = '0; st_a = '0; st_b = '0;
    endtask

    task automatic load_stack(input logic [31:0] below, input logic [31:0] top, input int n);
        stk.delete();
        if (n >= 2) stk.push_back(below);
        if (n >= 1) stk.push_back(top);
    endtask

    // Issue one op and run until the sequencer is idle again or reports an error.
    task automatic do_op(input logic [3:0] op, input int dly);
        clear_obs();
        alu_pend = 1'b0;
        alu_dly  = dly;
        op_aluop = op;
        op_valid = 1'b1;
        acc_cyc  = cyc;
        tick();
        op_valid = 1'b0;
        end_cyc  = -1;
        end_err  = '0;
        for (int i = 0; i < 200; i++) begin
            if (op_ready || err_code != 0) begin
                end_cyc = cyc;
                end_err = err_code;
                break;
            end
            tick();
        end
        if (end_cyc < 0) begin
            n_checks++; n_fails++;
            $display("FAIL op_end: op %h did not finish within 200 cycles", op);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        n_checks++;
        if ({op_ready, busy, stack_pop, stack_push, alu_start, err_code, alu_op, alu_a, alu_b, stack_wdata} !== '0) begin
            n_fails++; $display("FAIL reset_outputs: got ready=%b busy=%b err=%0d, required all zero", op_ready, busy, err_code);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({op_ready, busy} !== 2'b10) begin
            n_fails++; $display("FAIL reset_release: got ready=%b busy=%b, required 1/0", op_ready, busy);
        end
    endtask

    task automatic test_iadd();
        load_stack(32'd7, 32'd5, 2);
        do_op(4'h0, 0);
        n_checks++;
        if ({st_a, st_b} !== {32'd7, 32'd5}) begin
            n_fails++; $display("FAIL iadd_operands: got A=%0d B=%0d, required 7/5", st_a, st_b);
        end
        n_checks++;
        if (start_cyc - acc_cyc !== 4) begin
            n_fails++; $display("FAIL iadd_start_lat: got %0d, required 4", start_cyc - acc_cyc);
        end
        n_checks++;
        if (push_val !== 32'd12 || push_cyc - acc_cyc !== 5) begin
            n_fails++; $display("FAIL iadd_push: got %0d at +%0d, required 12 at +5", push_val, push_cyc - acc_cyc);
        end
        n_checks++;
        if (end_cyc - acc_cyc !== 6 || end_err !== 3'd0) begin
            n_fails++; $display("FAIL iadd_ready: got +%0d err=%0d, required +6 err=0", end_cyc - acc_cyc, end_err);
        end
        n_checks++;
        if (stk.size() != 1 || pop_n != 2) begin
            n_fails++; $display("FAIL iadd_stack: got depth=%0d pops=%0d, required 1/2", stk.size(), pop_n);
        end
    endtask

    task automatic test_idiv();
        load_stack(32'd20, 32'd3, 2);
        do_op(4'h3, 3);
        n_checks++;
        if (push_val !== 32'd6 || end_err !== 3'd0 || push_cyc - acc_cyc !== 8) begin
            n_fails++; $display("FAIL idiv_wait: got %0d at +%0d err=%0d, required 6 at +8 err=0", push_val, push_cyc - acc_cyc, end_err);
        end
    endtask

    task automatic test_ineg();
        load_stack(32'd0, 32'd9, 1);
        do_op(4'h5, 0);
        n_checks++;
        if (pop_n != 1 || {st_a, st_b} !== {32'd9, 32'd0}) begin
            n_fails++; $display("FAIL ineg_operands: got pops=%0d A=%0d B=%0d, required 1/9/0", pop_n, st_a, st_b);
        end
        n_checks++;
        if (push_val !== (32'd0 - 32'd9) || push_cyc - acc_cyc !== 4 || end_cyc - acc_cyc !== 5) begin
            n_fails++; $display("FAIL ineg_push: got %h at +%0d ready +%0d, required fffffff7 at +4 ready +5", push_val, push_cyc - acc_cyc, end_cyc - acc_cyc);
        end
        stk.delete();
        do_op(4'h5, 0);
        n_checks++;
        if (end_err !== 3'd1 || pop_n != 0 || end_cyc - acc_cyc !== 2) begin
            n_fails++; $display("FAIL ineg_underflow: got err=%0d pops=%0d at +%0d, required 1/0/+2", end_err, pop_n, end_cyc - acc_cyc);
        end
        err_clear = 1'b1; tick(); err_clear = 1'b0;
    endtask

    task automatic test_illegal();
        load_stack(32'd1, 32'd2, 2);
        do_op(4'hA, 0);
        n_checks++;
        if (end_err !== 3'd2 || pop_n != 0 || busy !== 1'b1 || op_ready !== 1'b0) begin
            n_fails++; $display("FAIL illegal_err: got err=%0d pops=%0d busy=%b ready=%b, required 2/0/1/0", end_err, pop_n, busy, op_ready);
        end
        tick(); tick();
        n_checks++;
        if (err_code !== 3'd2) begin
            n_fails++; $display("FAIL illegal_hold: got err=%0d, required 2", err_code);
        end
        err_clear = 1'b1; tick(); err_clear = 1'b0;
        n_checks++;
        if (err_code !== 3'd0 || op_ready !== 1'b1 || stk.size() != 2) begin
            n_fails++; $display("FAIL illegal_clear: got err=%0d ready=%b depth=%0d, required 0/1/2", err_code, op_ready, stk.size());
        end
    endtask

    task automatic test_timeout();
        load_stack(32'd3, 32'd4, 2);
        do_op(4'h0, TIMEOUT);
        n_checks++;
        if (end_err !== 3'd0 || push_val !== 32'd7 || push_cyc - acc_cyc !== 4 + TIMEOUT + 1) begin
            n_fails++; $display("FAIL done_at_limit: got err=%0d %0d at +%0d, required 0/7/+%0d", end_err, push_val, push_cyc - acc_cyc, 5 + TIMEOUT);
        end
        load_stack(32'd1, 32'd2, 2);
        do_op(4'h0, 1000);
        n_checks++;
        if (end_err !== 3'd3 || push_n != 0 || start_n != 1 || end_cyc - acc_cyc !== 4 + TIMEOUT + 1) begin
            n_fails++; $display("FAIL timeout: got err=%0d pushes=%0d starts=%0d at +%0d, required 3/0/1/+%0d", end_err, push_n, start_n, end_cyc - acc_cyc, 5 + TIMEOUT);
        end
        err_clear = 1'b1; tick(); err_clear = 1'b0;
    endtask

    task automatic test_divzero();
        logic [2:0] exp_err;
        int         exp_n;
        exp_err = TRAP ? 3'd4 : 3'd0;
        exp_n   = TRAP ? 0 : 1;
        load_stack(32'd20, 32'd0, 2);
        do_op(4'h3, 0);
        n_checks++;
        if (end_err !== exp_err || start_n != exp_n || push_n != exp_n || stk.size() != exp_n) begin
            n_fails++; $display("FAIL divzero: got err=%0d starts=%0d pushes=%0d depth=%0d, required %0d/%0d/%0d/%0d",
                                end_err, start_n, push_n, stk.size(), exp_err, exp_n, exp_n, exp_n);
        end
        if (push_n != 0) begin
            n_checks++;
            if (push_val !== ref_alu(4'h3, 32'd20, 32'd0)) begin
                n_fails++; $display("FAIL divzero_value: got %h, required %h", push_val, ref_alu(4'h3, 32'd20, 32'd0));
            end
        end
        if (end_err != 0) begin
            err_clear = 1'b1; tick(); err_clear = 1'b0;
        end
    endtask

    task automatic test_reset_in_wait();
        load_stack(32'd4, 32'd6, 2);
        clear_obs();
        alu_pend = 1'b0; alu_dly = 20;
        op_aluop = 4'h0; op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        for (int i = 0; i < 10 && start_n == 0; i++) tick();
        tick(); tick();
        n_checks++;
        if (busy !== 1'b1 || start_n != 1) begin
            n_fails++; $display("FAIL rst_wait_setup: got busy=%b starts=%0d, required 1/1", busy, start_n);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({op_ready, busy, stack_pop, stack_push, alu_start, err_code, alu_op, alu_a, alu_b, stack_wdata} !== '0) begin
            n_fails++; $display("FAIL rst_wait_outputs: got ready=%b busy=%b a=%0d b=%0d, required all zero", op_ready, busy, alu_a, alu_b);
        end
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        n_checks++;
        if (push_n != 0 || pop_n != 2 || stk.size() != 0 || op_ready !== 1'b1) begin
            n_fails++; $display("FAIL rst_wait_after: got pushes=%0d pops=%0d depth=%0d ready=%b, required 0/2/0/1", push_n, pop_n, stk.size(), op_ready);
        end
    endtask

    task automatic test_random(input int iters);
        logic [31:0] mdl[$];
        logic [3:0]  op;
        logic [2:0]  exp_err;
        logic [31:0] ea, eb, ev;
        int          n, dly, exp_pops, off, st_off;
        bit          exp_push, exp_start, same;
        for (int it = 0; it < iters; it++) begin
            stk.delete();
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 3);
            for (int k = 0; k < n; k++) stk.push_back(($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
            op  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'(legal_ops[$urandom_range(0, 10)]);
            dly = ($urandom_range(0, 9) == 0) ? TIMEOUT + 6 : $urandom_range(0, 4);

            mdl = stk;
            exp_err = 3'd0; exp_pops = 0; exp_push = 0; exp_start = 0;
            ea = '0; eb = '0; ev = '0; off = 0; st_off = 0;
            if (!(op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hC, 4'hD, 4'hF})) begin
                exp_err = 3'd2; off = 1;
            end else if (op == 4'h5) begin
                if (mdl.size() == 0) begin exp_err = 3'd1; off = 2; end
                else begin ea = mdl.pop_back(); exp_pops = 1; st_off = 3; end
            end else begin
                if (mdl.size() == 0) begin exp_err = 3'd1; off = 2; end
                else if (mdl.size() == 1) begin void'(mdl.pop_back()); exp_pops = 1; exp_err = 3'd1; off = 3; end
                else begin eb = mdl.pop_back(); ea = mdl.pop_back(); exp_pops = 2; st_off = 4; end
            end
            if (st_off != 0) begin
                if (TRAP && (op == 4'h3 || op == 4'h4) && eb == 0) begin
                    exp_err = 3'd4; off = st_off + 1;
                end else begin
                    exp_start = 1;
                    if (dly > TIMEOUT) begin
                        exp_err = 3'd3; off = st_off + TIMEOUT + 1;
                    end else begin
                        exp_push = 1; ev = ref_alu(op, ea, eb); mdl.push_back(ev); off = st_off + dly + 2;
                    end
                end
            end

            do_op(op, dly);
            n_checks++;
            if (end_err !== exp_err || end_cyc - acc_cyc !== off) begin
                n_fails++; $display("FAIL rand_end[%0d]: op %h got err=%0d at +%0d, required err=%0d at +%0d", it, op, end_err, end_cyc - acc_cyc, exp_err, off);
            end
            n_checks++;
            if (pop_n != exp_pops || push_n != int'(exp_push) || start_n != int'(exp_start) || both_n != 0) begin
                n_fails++; $display("FAIL rand_counts[%0d]: op %h got pops=%0d pushes=%0d starts=%0d both=%0d, required %0d/%0d/%0d/0",
                                    it, op, pop_n, push_n, start_n, both_n, exp_pops, exp_push, exp_start);
            end
            if (exp_start) begin
                n_checks++;
                if (st_a !== ea || st_b !== eb || start_cyc - acc_cyc !== st_off) begin
                    n_fails++; $display("FAIL rand_issue[%0d]: got A=%h B=%h at +%0d, required %h/%h at +%0d", it, st_a, st_b, start_cyc - acc_cyc, ea, eb, st_off);
                end
            end
            if (exp_push) begin
                n_checks++;
                if (push_val !== ev) begin
                    n_fails++; $display("FAIL rand_result[%0d]: op %h got %h, required %h", it, op, push_val, ev);
                end
            end
            same = (mdl.size() == stk.size());
            for (int k = 0; k < mdl.size() && same; k++) same = (mdl[k] === stk[k]);
            n_checks++;
            if (!same) begin
                n_fails++; $display("FAIL rand_stack[%0d]: got depth %0d, required depth %0d with matching contents", it, stk.size(), mdl.size());
            end
            if (end_err != 0) begin
                err_clear = 1'b1; tick(); err_clear = 1'b0;
                n_checks++;
                if (err_code !== 3'd0 || op_ready !== 1'b1) begin
                    n_fails++; $display("FAIL rand_clear[%0d]: got err=%0d ready=%b, required 0/1", it, err_code, op_ready);
                end
            end
        end
    endtask

    initial begin
        op_valid = 1'b0; op_aluop = '0; stack_empty = 1'b1; stack_rdata = '0;
        alu_done = 1'b0; alu_result = '0; err_clear = 1'b0;
        pend_pop = 1'b0; pend_push = 1'b0; pend_wdata = '0;
        alu_pend = 1'b0; alu_dly = 0; alu_cnt = 0; alu_res = '0;
        clear_obs();
        test_reset();
        test_iadd();
        test_idiv();
        test_ineg();
        test_illegal();
        test_timeout();
        test_divzero();
        test_reset_in_wait();
        test_random(40);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
